// File: rtl/mem_burst_reader.sv
// Burst reader for a 1024 x 8 memory with a synchronous read port.
// Issues one read per cycle and streams bytes through a 2-entry buffer on valid/ready.
module mem_burst_reader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1 << ADDR_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  issue_q, issue_d;
  logic [LEN_W-1:0]  deliver_q, deliver_d;
  logic [1:0]        count_q, count_d;
  logic              rd_ptr_q, wr_ptr_q;
  logic              inflight_q;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] buf_q [2];

  logic       pop;
  logic       push;
  logic       issue;
  logic [1:0] slots_used;
  logic       len_ok;

  // Buffer entries plus the read in flight, minus what leaves this cycle,
  // is what the buffer must hold next cycle; never exceeds 2.
  assign pop        = (count_q != 2'd0) && out_ready;
  assign push       = inflight_q;
  assign slots_used = count_q + {1'b0, inflight_q} - {1'b0, pop};
  assign len_ok     = (length != '0) && (length <= MAX_LEN);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    issue_d   = issue_q;
    deliver_d = deliver_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    issue     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_ok) begin
            addr_d    = start_addr;
            issue_d   = length;
            deliver_d = length;
            state_d   = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if ((issue_q != '0) && (slots_used < 2'd2)) begin
          issue   = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
          issue_d = issue_q - LEN_W'(1);
          if (issue_q == LEN_W'(1)) state_d = S_DRAIN;
        end
      end
      default: ;
    endcase

    // The final pop always trails the final issue by at least two cycles.
    if ((state_q != S_IDLE) && pop) begin
      deliver_d = deliver_q - LEN_W'(1);
      if (deliver_q == LEN_W'(1)) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    end

    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      issue_q    <= '0;
      deliver_q  <= '0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      issue_q    <= issue_d;
      deliver_q  <= deliver_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_q ^ pop;
      wr_ptr_q   <= wr_ptr_q ^ push;
      inflight_q <= issue;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // NOTE: buffer storage is not reset; count_q gates every read so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr_q] <= mem_rdata;
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign mem_en    = issue;
  assign mem_addr  = addr_q;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = out_valid ? buf_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed bench for mem_burst_reader: stimulus pushes expected bytes/addresses
// into queues; a negedge monitor pops and compares whatever the DUT emits.
module tb_mem_burst_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  start_addr;
  logic [10:0] length;
  logic        busy, done, err;
  logic        mem_en;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_rdata;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  mem_burst_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .mem_en     (mem_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [1024];
  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [9:0] exp_addr_q[$];

  int  iss, pops;
  int  total_pops   = 0;
  int  total_issues = 0;
  int  done_total   = 0;
  bit  rdy_rand     = 1'b0;
  bit  prev_valid, prev_ready;
  logic [7:0] prev_data;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (done) done_total++;
    if (!rst_n) begin
      iss = 0; pops = 0; prev_valid = 1'b0; prev_ready = 1'b1; prev_data = '0;
    end else begin
      if (mem_en) begin
        total_issues++;
        if (exp_addr_q.size() == 0) check("unexpected_issue", 1, 0);
        else check("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
        check("outstanding_le2", 32'((iss - pops + 1 - int'(out_valid && out_ready)) <= 2), 1);
        iss++;
      end
      if (prev_valid && !prev_ready) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_byte", 32'(out_data), 32'hFFFF);
        else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        pops++;
        total_pops++;
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_data  = out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_model(input logic [9:0] a, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mem[10'(int'(a) + i)]);
  endtask

  task automatic run_burst(input logic [9:0] a, input int n, input bit rand_rdy);
    int k, first_v, done_k;
    for (int i = 0; i < n; i++) exp_addr_q.push_back(10'(int'(a) + i));
    tick();
    start_addr = a; length = 11'(n); start = 1'b1;
    rdy_rand = rand_rdy;
    if (!rand_rdy) out_ready = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    k = 0; first_v = -1; done_k = -1;
    while (done_k < 0 && k < 4 * n + 50) begin
      tick();
      k++;
      if (out_valid && first_v < 0) first_v = k;
      if (done) begin
        done_k = k;
        check("busy_low_with_done", 32'(busy), 0);
      end
    end
    rdy_rand = 1'b0;
    out_ready = 1'b1;
    if (done_k < 0) check("done_timeout", 0, 1);
    else if (!rand_rdy) begin
      check("first_valid_cycle", 32'(first_v), 2);
      check("done_cycle", 32'(done_k), 32'(n + 2));
    end
    tick();
    check("done_one_pulse", 32'(done), 0);
    check("busy_after_done", 32'(busy), 0);
    check("bytes_left", 32'(exp_q.size()), 0);
    check("addrs_left", 32'(exp_addr_q.size()), 0);
  endtask

  task automatic bad_start(input logic [10:0] len);
    int issues_before;
    issues_before = total_issues;
    tick();
    start_addr = 10'h123; length = len; start = 1'b1;
    tick();
    start = 1'b0;
    check("err_pulse", 32'(err), 1);
    check("err_busy", 32'(busy), 0);
    tick();
    check("err_one_pulse", 32'(err), 0);
    check("err_busy_after", 32'(busy), 0);
    repeat (3) tick();
    check("err_no_issue", 32'(total_issues), 32'(issues_before));
  endtask

  task automatic check_reset_state();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_mem_en", 32'(mem_en), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
  endtask

  initial begin
    int base, w, dones_before;
    rst_n = 1'b0; start = 1'b0; start_addr = '0; length = '0; out_ready = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    repeat (2) tick();
    check_reset_state();
    rst_n = 1'b1;

    // 16-byte burst from 0, full rate.
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    run_burst(10'h000, 16, 1'b0);

    // Wrap across the top of memory.
    mem[10'h3FE] = 8'hAA; mem[10'h3FF] = 8'hBB; mem[10'h000] = 8'hCC; mem[10'h001] = 8'hDD;
    exp_q.push_back(8'hAA); exp_q.push_back(8'hBB);
    exp_q.push_back(8'hCC); exp_q.push_back(8'hDD);
    run_burst(10'h3FE, 4, 1'b0);

    // Same 16-byte burst under random backpressure.
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    run_burst(10'h000, 16, 1'b1);

    // Illegal lengths.
    bad_start(11'd0);
    bad_start(11'd1025);

    // Full-memory burst from 0x200.
    for (int i = 0; i < 1024; i++) mem[i] = 8'((i * 37 + 5) ^ (i >> 8));
    push_model(10'h200, 1024);
    run_burst(10'h200, 1024, 1'b0);

    // Abort a 100-byte burst with reset after byte 10, then a fresh 3-byte burst.
    dones_before = done_total;
    push_model(10'h100, 100);
    for (int i = 0; i < 100; i++) exp_addr_q.push_back(10'(10'h100 + i));
    tick();
    start_addr = 10'h100; length = 11'd100; start = 1'b1;
    tick();
    start = 1'b0;
    base = total_pops; w = 0;
    while (total_pops - base < 10 && w < 200) begin tick(); w++; end
    check("abort_reached_byte10", 32'(total_pops - base >= 10), 1);
    rst_n = 1'b0;
    tick();
    check_reset_state();
    exp_q.delete();
    exp_addr_q.delete();
    rst_n = 1'b1;
    repeat (4) tick();
    check("abort_no_done", 32'(done_total), 32'(dones_before));
    check("abort_idle_valid", 32'(out_valid), 0);
    push_model(10'h050, 3);
    run_burst(10'h050, 3, 1'b0);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_burst_reader.md
Name: mem_burst_reader

Overview:
- Initiator-side burst reader for the team's 1024 x 8 byte memory model, which has a synchronous read port.
- Takes a start address and a byte count.
- Issues one memory read per cycle.
- Streams the returned bytes out on a valid/ready interface.
- A 2-entry output buffer absorbs downstream backpressure without dropping or duplicating bytes.

Parameters:
ADDR_W, 10, memory address width (depth = 2**ADDR_W = 1024)
DATA_W, 8, memory/stream data width
LEN_W, 11, burst length width (max legal length 1024)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  burst request, sampled only in IDLE
start_addr  input  ADDR_W  first byte address of burst
length  input  LEN_W  number of bytes to read
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse when the last byte is accepted downstream
err  output  1  one-cycle pulse when start has length==0 or length>1024
mem_en  output  1  memory read enable
mem_addr  output  ADDR_W  memory read address
mem_rdata  input  DATA_W  memory read data, valid exactly 1 cycle after mem_en
out_data  output  DATA_W  stream byte
out_valid  output  1  stream byte valid
out_ready  input  1  downstream accept

Behaviour:
- Reset (rst_n low at a clk edge):
  - State returns to IDLE.
  - Outputs: busy=0, done=0, err=0, mem_en=0, mem_addr=0, out_valid=0, out_data=0.
  - Buffer is emptied, the issue/deliver counters clear, and any in-flight read is discarded.
  - Reset applied mid-burst aborts the burst. No done pulse is produced. Data returning from a discarded read is ignored.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start with 1<=length<=1024: latch start_addr into the address counter and length into the remaining-issue and remaining-deliver counters; go to RUN; busy=1 next cycle.
  - start with length==0 or length>1024: pulse err next cycle, stay IDLE, no memory access.
  - Without start, or in any other state, start is ignored.
- Issue rule (RUN):
  - mem_en=1 when remaining-issue>0 and (occupancy + inflight - pop) < 2.
    - occupancy = buffer entries, 0..2.
    - inflight = mem_en of the previous cycle.
    - pop = out_valid & out_ready this cycle.
  - On each issue: address increments modulo 1024 (0x3FF wraps to 0x000) and remaining-issue decrements.
  - mem_en and mem_addr are combinational from registered state and out_ready, or registered with equivalent timing. Either way, byte N's address is presented exactly once.
  - When remaining-issue reaches 0, go to DRAIN.
- Data capture: the cycle after mem_en, mem_rdata is written to the buffer tail. The issue rule guarantees the buffer never overflows.
- Output:
  - out_data and out_valid reflect the buffer head.
  - A pop and a push in the same cycle are both honored; occupancy is unchanged.
  - Bytes leave strictly in address order.
- DRAIN:
  - No issues.
  - When the final byte pops (remaining-deliver goes 1->0), pulse done for 1 cycle and return to IDLE; busy falls in the same cycle that done is high.
- Throughput and latency:
  - With out_ready held 1, out_valid first asserts 2 cycles after the accepted start edge.
  - The stream then runs 1 byte/cycle; an N-byte burst completes in N+2 cycles.
- Backpressure: with out_ready=0, at most 2 bytes are buffered and issue stalls. When out_ready returns to 1, full rate resumes with no gaps beyond the pipeline refill.
- Length 1024 starting at any address reads every location exactly once, with wrap.
- out_data is held stable while out_valid=1 and out_ready=0.

Test Plan:
- Preload mem[0x000..0x00F]=0x00..0x0F, out_ready=1, start_addr=0x000, length=16 -> out_valid high from cycle 2; bytes 0x00..0x0F on 16 consecutive cycles; done pulses once; busy low afterwards.
- start_addr=0x3FE, length=4, mem[0x3FE]=0xAA, [0x3FF]=0xBB, [0x000]=0xCC, [0x001]=0xDD -> stream AA,BB,CC,DD; mem_addr sequence 3FE,3FF,000,001.
- Same 16-byte burst with out_ready toggling pseudo-randomly (~50%) -> exactly 16 bytes, in order, no duplicates; never more than 2 reads outstanding unconsumed; out_data stable while stalled.
- start with length=0, then with length=1025 -> err pulses each time, mem_en never asserts, busy stays 0.
- length=1024 from 0x200 with out_ready=1 -> 1024 bytes matching mem[(0x200+i)%1024]; done pulses at cycle 1026.
- Start a 100-byte burst; assert rst_n=0 for 1 cycle after byte 10; then issue a fresh length=3 burst at 0x050 -> no done for the aborted burst; the new stream is exactly mem[0x050..0x052].
